step_driver: RTL and testbench
==============================

# step_driver

Downstream of the circular interpolator. Converts its one-cycle X_acc/X_dec/Y_acc/Y_dec motion pulses into per-axis STEP/DIR waveforms for external stepper drivers. Each axis has a small FIFO that absorbs interpolator bursts, direction-setup and pulse-width timing, and a signed position counter. The block reports sticky overflow and conflict flags. It also raises a completion pulse once the interpolator's draw_overH has been seen and all buffered steps have been emitted.

## Interface
- FIFO_DEPTH, 8, entries per axis FIFO; power of 2, ≥2
- STEP_HIGH, 4, pulse_clk cycles STEP held high; ≥1
- STEP_LOW, 4, pulse_clk cycles STEP held low after each pulse; ≥1
- DIR_SETUP, 2, cycles DIR is stable before STEP rises after a direction change; ≥1
- POS_W, 16, position counter width

- pulse_clk  in  1  clock
- sys_rst_l  in  1  reset, asynchronous, active-low
- X_acc, X_dec, Y_acc, Y_dec  in  1 each  one-cycle step requests from the interpolator (acc = +1, dec = −1)
- draw_overH  in  1  interpolator segment-complete
- clr_pos  in  1  synchronous clear of positions and sticky flags
- X_step, Y_step  out  1  step pulses
- X_dir, Y_dir  out  1  direction; 1 = positive
- X_pos, Y_pos  out  POS_W signed  commanded position, two's complement
- fifo_ovf  out  1  sticky; a request was dropped on a full FIFO
- cmd_err  out  1  sticky; acc and dec on the same axis in the same cycle
- busy  out  1  any FIFO non-empty or any axis FSM not IDLE
- motion_done  out  1  one-cycle completion pulse

## Operation
- Reset values: all outputs 0; FIFOs empty; FSMs IDLE; completion-pending flag 0.
- Capture, per axis, at each edge:
  - acc alone pushes dir=1; dec alone pushes dir=0.
  - acc and dec together: no push, cmd_err set.
  - Push while full: request dropped, fifo_ovf set. Full is evaluated before any same-cycle pop.
- Axis FSM, states IDLE, SETUP, HIGH, LOW:
  - IDLE with FIFO non-empty: pop. If the popped dir equals current dir, go to HIGH. Otherwise update dir and go to SETUP.
  - SETUP: hold DIR_SETUP cycles, then HIGH.
  - HIGH: step=1 for STEP_HIGH cycles, then LOW.
  - LOW: step=0 for STEP_LOW cycles, then IDLE.
- Position counter:
  - Updates on entry to HIGH: +1 if dir=1, −1 if dir=0.
  - Wraps modulo 2^POS_W; no saturation.
- clr_pos:
  - Zeroes X_pos, Y_pos, fifo_ovf and cmd_err at the next edge.
  - Takes priority over a same-edge position update and over a same-edge flag set.
  - Does not touch the FIFOs, FSMs or dir.
- Completion:
  - draw_overH sampled high sets the pending flag.
  - When pending, both FIFOs are empty and both FSMs are IDLE, motion_done=1 for one cycle and pending clears.
  - draw_overH re-asserted while pending has no extra effect.
- Async reset mid-pulse: step drops immediately, all buffered requests are discarded, positions go to 0.

## Timing
- Request sampled at edge E, no dir change: step rises and pos updates at edge E+1.
- With dir change: dir toggles at E+1; step rises at E+1+DIR_SETUP.
- Minimum step period, same direction: STEP_HIGH+STEP_LOW+1 cycles (the IDLE pop cycle is included).
- The interpolator issues at most one request every 2 cycles. A FIFO overflows only for runs longer than FIFO_DEPTH at a step period above 2 cycles.
- X and Y run fully independently; simultaneous X and Y steps are allowed.
- busy and motion_done are registered. motion_done occurs no earlier than 1 cycle after the last LOW phase ends.

## Structure
- Package step_drv_pkg holds:
  - the axis state enum (IDLE/SETUP/HIGH/LOW)
  - default parameter constants
- Sub-module step_axis holds FIFO, FSM, timer and position counter for one axis. It is instantiated twice.
- The top level holds only capture/conflict logic, sticky flags, busy and completion.

## Test plan
- Single X_acc from reset, default params → X_dir 0→1 at E+1; X_step high at E+3 for 4 cycles; X_pos=1; then motion_done after draw_overH.
- 5 Y_dec pulses every 2 cycles → Y_dir=0; five Y_step pulses, each 4 high / 4 low with 1 idle cycle between; Y_pos=−5; fifo_ovf=0.
- 12 back-to-back X_acc (every 2 cycles), FIFO_DEPTH=8, STEP_HIGH=STEP_LOW=4 → fifo_ovf=1; X_pos equals the accepted count (<12); busy falls after drain.
- X_acc and X_dec in the same cycle → no step; cmd_err=1; X_pos unchanged. clr_pos then → cmd_err=0.
- Alternating X_acc/X_dec → DIR_SETUP gap before every pulse; X_pos returns to 0.
- sys_rst_l low while X_step is high with 3 entries queued → X_step=0 immediately; after release no further steps, X_pos=0, busy=0.

Source files
------------

// File: rtl/step_drv_pkg.sv
// Shared types and default parameters for the step_driver block and its per-axis engine.
package step_drv_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SETUP = 2'd1,
    ST_HIGH  = 2'd2,
    ST_LOW   = 2'd3
  } axis_state_e;

  localparam int DEF_FIFO_DEPTH = 8;
  localparam int DEF_STEP_HIGH  = 4;
  localparam int DEF_STEP_LOW   = 4;
  localparam int DEF_DIR_SETUP  = 2;
  localparam int DEF_POS_W      = 16;

  function automatic int max3(input int a, input int b, input int c);
    int m;
    m = (a > b) ? a : b;
    return (m > c) ? m : c;
  endfunction

endpackage

// File: rtl/step_axis.sv
// One stepper axis: request FIFO, STEP/DIR timing FSM and signed position counter.
module step_axis
  import step_drv_pkg::*;
#(
  parameter int FIFO_DEPTH = DEF_FIFO_DEPTH,
  parameter int STEP_HIGH  = DEF_STEP_HIGH,
  parameter int STEP_LOW   = DEF_STEP_LOW,
  parameter int DIR_SETUP  = DEF_DIR_SETUP,
  parameter int POS_W      = DEF_POS_W
) (
  input  logic                    pulse_clk,
  input  logic                    sys_rst_l,
  input  logic                    push_i,
  input  logic                    push_dir_i,
  input  logic                    clr_pos_i,
  output logic                    full_o,
  output logic                    empty_o,
  output logic                    idle_o,
  output logic                    step_o,
  output logic                    dir_o,
  output logic signed [POS_W-1:0] pos_o
);

  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam int CNT_W = $clog2(max3(STEP_HIGH, STEP_LOW, DIR_SETUP) + 1);
  localparam logic [PTR_W:0] PTR_ONE = (PTR_W+1)'(1);
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

  logic [FIFO_DEPTH-1:0] fifo_q;
  logic [PTR_W:0]        wr_ptr_q, rd_ptr_q;
  axis_state_e           state_q, state_d;
  logic [CNT_W-1:0]      cnt_q, cnt_d;
  logic                  dir_q, dir_d;
  logic                  step_q;
  logic [POS_W-1:0]      pos_q, pos_d;
  logic                  push_ok, pop, head_dir, enter_high;

  assign empty_o  = (wr_ptr_q == rd_ptr_q);
  assign full_o   = (wr_ptr_q[PTR_W] != rd_ptr_q[PTR_W]) &&
                    (wr_ptr_q[PTR_W-1:0] == rd_ptr_q[PTR_W-1:0]);
  assign push_ok  = push_i && !full_o;
  assign pop      = (state_q == ST_IDLE) && !empty_o;
  assign head_dir = fifo_q[rd_ptr_q[PTR_W-1:0]];

  // NOTE: storage carries no reset; emptiness is defined by the pointers alone,
  // so resetting them discards every buffered request without clearing the array.
  always_ff @(posedge pulse_clk) begin
    if (push_ok) fifo_q[wr_ptr_q[PTR_W-1:0]] <= push_dir_i;
  end

  // NOTE: every always_comb output gets a default first so no path can infer a latch.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    dir_d   = dir_q;
    unique case (state_q)
      ST_IDLE: begin
        if (!empty_o) begin
          if (head_dir == dir_q) begin
            state_d = ST_HIGH;
            cnt_d   = CNT_W'(STEP_HIGH - 1);
          end else begin
            dir_d   = head_dir;
            state_d = ST_SETUP;
            cnt_d   = CNT_W'(DIR_SETUP - 1);
          end
        end
      end
      ST_SETUP: begin
        if (cnt_q == '0) begin
          state_d = ST_HIGH;
          cnt_d   = CNT_W'(STEP_HIGH - 1);
        end else begin
          cnt_d = cnt_q - CNT_ONE;
        end
      end
      ST_HIGH: begin
        if (cnt_q == '0) begin
          state_d = ST_LOW;
          cnt_d   = CNT_W'(STEP_LOW - 1);
        end else begin
          cnt_d = cnt_q - CNT_ONE;
        end
      end
      ST_LOW: begin
        if (cnt_q == '0) state_d = ST_IDLE;
        else             cnt_d   = cnt_q - CNT_ONE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // dir_q is already the pulse direction whenever HIGH is entered.
  assign enter_high = (state_d == ST_HIGH) && (state_q != ST_HIGH);

  always_comb begin
    pos_d = pos_q;
    if (clr_pos_i)       pos_d = '0;
    else if (enter_high) pos_d = pos_q + (dir_q ? POS_W'(1) : {POS_W{1'b1}});
  end

  // NOTE: sequential state uses non-blocking assignments so all registers update together.
  always_ff @(posedge pulse_clk or negedge sys_rst_l) begin
    if (!sys_rst_l) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      state_q  <= ST_IDLE;
      cnt_q    <= '0;
      dir_q    <= 1'b0;
      step_q   <= 1'b0;
      pos_q    <= '0;
    end else begin
      if (push_ok) wr_ptr_q <= wr_ptr_q + PTR_ONE;
      if (pop)     rd_ptr_q <= rd_ptr_q + PTR_ONE;
      state_q <= state_d;
      cnt_q   <= cnt_d;
      dir_q   <= dir_d;
      step_q  <= (state_d == ST_HIGH);
      pos_q   <= pos_d;
    end
  end

  assign idle_o = (state_q == ST_IDLE);
  assign step_o = step_q;
  assign dir_o  = dir_q;
  assign pos_o  = pos_q;

endmodule

// File: rtl/step_driver.sv
// Turns interpolator acc/dec pulses into buffered STEP/DIR waveforms for two axes,
// with sticky error flags, a busy indicator and a registered completion pulse.
module step_driver
  import step_drv_pkg::*;
#(
  parameter int FIFO_DEPTH = DEF_FIFO_DEPTH,
  parameter int STEP_HIGH  = DEF_STEP_HIGH,
  parameter int STEP_LOW   = DEF_STEP_LOW,
  parameter int DIR_SETUP  = DEF_DIR_SETUP,
  parameter int POS_W      = DEF_POS_W
) (
  input  logic                    pulse_clk,
  input  logic                    sys_rst_l,
  input  logic                    X_acc,
  input  logic                    X_dec,
  input  logic                    Y_acc,
  input  logic                    Y_dec,
  input  logic                    draw_overH,
  input  logic                    clr_pos,
  output logic                    X_step,
  output logic                    Y_step,
  output logic                    X_dir,
  output logic                    Y_dir,
  output logic signed [POS_W-1:0] X_pos,
  output logic signed [POS_W-1:0] Y_pos,
  output logic                    fifo_ovf,
  output logic                    cmd_err,
  output logic                    busy,
  output logic                    motion_done
);

  logic x_push, y_push, x_conflict, y_conflict;
  logic x_full, y_full, x_empty, y_empty, x_idle, y_idle;
  logic ovf_q, ovf_d, err_q, err_d;
  logic busy_q, busy_d, pending_q, pending_d, done_q, done_d;

  // Opposing requests on one axis cancel: nothing is queued and the conflict is flagged.
  assign x_push     = X_acc ^ X_dec;
  assign y_push     = Y_acc ^ Y_dec;
  assign x_conflict = X_acc & X_dec;
  assign y_conflict = Y_acc & Y_dec;

  step_axis #(
    .FIFO_DEPTH(FIFO_DEPTH), .STEP_HIGH(STEP_HIGH), .STEP_LOW(STEP_LOW),
    .DIR_SETUP(DIR_SETUP), .POS_W(POS_W)
  ) u_x_axis (
    .pulse_clk (pulse_clk), .sys_rst_l(sys_rst_l),
    .push_i    (x_push),    .push_dir_i(X_acc), .clr_pos_i(clr_pos),
    .full_o    (x_full),    .empty_o(x_empty),  .idle_o(x_idle),
    .step_o    (X_step),    .dir_o(X_dir),      .pos_o(X_pos)
  );

  step_axis #(
    .FIFO_DEPTH(FIFO_DEPTH), .STEP_HIGH(STEP_HIGH), .STEP_LOW(STEP_LOW),
    .DIR_SETUP(DIR_SETUP), .POS_W(POS_W)
  ) u_y_axis (
    .pulse_clk (pulse_clk), .sys_rst_l(sys_rst_l),
    .push_i    (y_push),    .push_dir_i(Y_acc), .clr_pos_i(clr_pos),
    .full_o    (y_full),    .empty_o(y_empty),  .idle_o(y_idle),
    .step_o    (Y_step),    .dir_o(Y_dir),      .pos_o(Y_pos)
  );

  always_comb begin
    ovf_d = ovf_q | (x_push & x_full) | (y_push & y_full);
    err_d = err_q | x_conflict | y_conflict;
    if (clr_pos) begin
      ovf_d = 1'b0;
      err_d = 1'b0;
    end
    busy_d    = !x_empty || !y_empty || !x_idle || !y_idle;
    done_d    = pending_q && !busy_d;
    // Completion consumes the pending flag even if draw_overH is re-asserted.
    pending_d = done_d ? 1'b0 : (pending_q | draw_overH);
  end

  always_ff @(posedge pulse_clk or negedge sys_rst_l) begin
    if (!sys_rst_l) begin
      ovf_q     <= 1'b0;
      err_q     <= 1'b0;
      busy_q    <= 1'b0;
      pending_q <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      ovf_q     <= ovf_d;
      err_q     <= err_d;
      busy_q    <= busy_d;
      pending_q <= pending_d;
      done_q    <= done_d;
    end
  end

  assign fifo_ovf    = ovf_q;
  assign cmd_err     = err_q;
  assign busy        = busy_q;
  assign motion_done = done_q;

endmodule

// File: tb/tb_step_driver.sv
// Directed bench for step_driver with default parameters; inputs change and outputs
// are sampled on the falling clock edge.
module tb_step_driver;

  logic pulse_clk = 1'b0;
  logic sys_rst_l;
  logic X_acc, X_dec, Y_acc, Y_dec, draw_overH, clr_pos;
  logic X_step, Y_step, X_dir, Y_dir;
  logic signed [15:0] X_pos, Y_pos;
  logic fifo_ovf, cmd_err, busy, motion_done;

  int vectors = 0;
  int miscompares = 0;
  int x_rises = 0, y_rises = 0, y_high = 0;
  int snap;
  logic x_prev = 1'b0, y_prev = 1'b0;

  step_driver dut (
    .pulse_clk  (pulse_clk),  .sys_rst_l(sys_rst_l),
    .X_acc      (X_acc),      .X_dec(X_dec),   .Y_acc(Y_acc), .Y_dec(Y_dec),
    .draw_overH (draw_overH), .clr_pos(clr_pos),
    .X_step     (X_step),     .Y_step(Y_step), .X_dir(X_dir), .Y_dir(Y_dir),
    .X_pos      (X_pos),      .Y_pos(Y_pos),
    .fifo_ovf   (fifo_ovf),   .cmd_err(cmd_err),
    .busy       (busy),       .motion_done(motion_done)
  );

  always #5 pulse_clk = ~pulse_clk;

  always @(negedge pulse_clk) begin
    if (X_step && !x_prev) x_rises++;
    if (Y_step && !y_prev) y_rises++;
    if (Y_step) y_high++;
    x_prev = X_step;
    y_prev = Y_step;
  end

  task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp_v);
    vectors++;
    assert (obs === exp_v) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp_v);
    end
  endtask

  task automatic cyc(input int n);
    repeat (n) @(negedge pulse_clk);
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    sys_rst_l = 1'b0;
    {X_acc, X_dec, Y_acc, Y_dec, draw_overH, clr_pos} = '0;
    cyc(2);
    check("rst_x_step", X_step, 0);
    check("rst_x_dir", X_dir, 0);
    check("rst_x_pos", X_pos, 0);
    check("rst_y_pos", Y_pos, 0);
    check("rst_ovf", fifo_ovf, 0);
    check("rst_err", cmd_err, 0);
    check("rst_busy", busy, 0);
    check("rst_done", motion_done, 0);
    sys_rst_l = 1'b1;
    cyc(1);

    // Single X_acc: direction change from reset value 0.
    X_acc = 1'b1; cyc(1); X_acc = 1'b0;             // edge E
    check("t1_dir_e", X_dir, 0);
    check("t1_step_e", X_step, 0);
    cyc(1);                                           // E+1
    check("t1_dir_e1", X_dir, 1);
    check("t1_step_e1", X_step, 0);
    check("t1_busy_e1", busy, 1);
    cyc(1);                                           // E+2
    check("t1_step_e2", X_step, 0);
    cyc(1);                                           // E+3
    check("t1_step_e3", X_step, 1);
    check("t1_pos_e3", X_pos, 1);
    cyc(3);                                           // E+6
    check("t1_step_e6", X_step, 1);
    cyc(1);                                           // E+7
    check("t1_step_e7", X_step, 0);
    cyc(4);                                           // E+11
    check("t1_busy_e11", busy, 1);
    cyc(1);                                           // E+12
    check("t1_busy_e12", busy, 0);
    draw_overH = 1'b1; cyc(1); draw_overH = 1'b0;
    check("t1_done_a", motion_done, 0);
    cyc(1);
    check("t1_done_b", motion_done, 1);
    cyc(1);
    check("t1_done_c", motion_done, 0);

    // Five Y_dec every 2 cycles, no direction change.
    snap = y_rises;
    Y_dec = 1'b1; cyc(1); Y_dec = 1'b0;             // E
    check("t2_step_e", Y_step, 0);
    cyc(1);                                           // E+1
    check("t2_step_e1", Y_step, 1);
    check("t2_pos_e1", Y_pos, 16'hFFFF);
    check("t2_dir", Y_dir, 0);
    for (int k = 1; k < 5; k++) begin
      Y_dec = 1'b1; cyc(1); Y_dec = 1'b0; cyc(1);
    end                                               // E+9
    cyc(36);                                          // E+45
    check("t2_busy_e45", busy, 1);
    cyc(1);                                           // E+46
    check("t2_busy_e46", busy, 0);
    check("t2_rises", 16'(y_rises - snap), 5);
    check("t2_high_cycles", 16'(y_high), 20);
    check("t2_pos", Y_pos, 16'hFFFB);
    check("t2_ovf", fifo_ovf, 0);

    // Twelve X_acc every 2 cycles overflow the 8-deep FIFO by one.
    clr_pos = 1'b1; cyc(1); clr_pos = 1'b0;
    check("t3_clr_x", X_pos, 0);
    check("t3_clr_y", Y_pos, 0);
    snap = x_rises;
    for (int k = 0; k < 12; k++) begin
      X_acc = 1'b1; cyc(1); X_acc = 1'b0; cyc(1);
    end                                               // E+23
    check("t3_ovf", fifo_ovf, 1);
    cyc(76);                                          // E+99
    check("t3_busy_e99", busy, 1);
    cyc(1);                                           // E+100
    check("t3_busy_e100", busy, 0);
    check("t3_pos", X_pos, 11);
    check("t3_rises", 16'(x_rises - snap), 11);

    // Conflicting request, then clr_pos winning over a same-edge conflict.
    X_acc = 1'b1; X_dec = 1'b1; cyc(1); X_acc = 1'b0; X_dec = 1'b0;
    check("t4_err", cmd_err, 1);
    cyc(3);
    check("t4_step", X_step, 0);
    check("t4_pos", X_pos, 11);
    check("t4_busy", busy, 0);
    clr_pos = 1'b1; X_acc = 1'b1; X_dec = 1'b1; cyc(1);
    clr_pos = 1'b0; X_acc = 1'b0; X_dec = 1'b0;
    check("t4_clr_err", cmd_err, 0);
    check("t4_clr_ovf", fifo_ovf, 0);
    check("t4_clr_pos", X_pos, 0);

    // Alternating dec/acc: each pulse preceded by a DIR_SETUP gap.
    snap = x_rises;
    for (int k = 0; k < 4; k++) begin
      X_acc = (k % 2) == 1; X_dec = (k % 2) == 0; cyc(1);
      X_acc = 1'b0; X_dec = 1'b0; cyc(1);
    end                                               // E+7
    cyc(4);                                           // E+11
    check("t5_dir_e11", X_dir, 0);
    check("t5_pos_e11", X_pos, 16'hFFFF);
    cyc(1);                                           // E+12
    check("t5_dir_e12", X_dir, 1);
    check("t5_step_e12", X_step, 0);
    cyc(1);                                           // E+13
    check("t5_step_e13", X_step, 0);
    cyc(1);                                           // E+14
    check("t5_step_e14", X_step, 1);
    check("t5_pos_e14", X_pos, 0);
    cyc(30);                                          // E+44
    check("t5_busy_e44", busy, 1);
    cyc(1);                                           // E+45
    check("t5_busy_e45", busy, 0);
    check("t5_pos", X_pos, 0);
    check("t5_dir", X_dir, 1);
    check("t5_rises", 16'(x_rises - snap), 4);

    // Asynchronous reset while STEP is high with three entries queued.
    snap = x_rises;
    X_acc = 1'b1; cyc(4); X_acc = 1'b0;              // E+3
    check("t6_step_pre", X_step, 1);
    check("t6_pos_pre", X_pos, 1);
    check("t6_busy_pre", busy, 1);
    #1 sys_rst_l = 1'b0;
    #1;
    check("t6_step_rst", X_step, 0);
    check("t6_pos_rst", X_pos, 0);
    check("t6_busy_rst", busy, 0);
    check("t6_dir_rst", X_dir, 0);
    cyc(1);
    sys_rst_l = 1'b1;
    cyc(20);
    check("t6_rises", 16'(x_rises - snap), 1);
    check("t6_step_post", X_step, 0);
    check("t6_pos_post", X_pos, 0);
    check("t6_busy_post", busy, 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
